// File: rtl/multiplicador_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    // One extra bit so the step counter cannot wrap inside an operation.
    function automatic int ancho_cuenta(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/sumadorCompletoN.sv
// N-bit adder with carry in/out, shared by the multiplier datapath.
module sumadorCompletoN #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] suma,
    output logic             cout
);

    assign {cout, suma} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/controlador_multiplicador.sv
// Shift-and-add multiplier controller: one multiplier bit per clock through a shared adder.
// Optional macro MULT_EARLY_EXIT_EN ends CALC as soon as no multiplier bits remain.
module controlador_multiplicador
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador,
    output logic                 listo,
    output logic                 valido,
    output logic [2*WIDTH-1:0]   resultado
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = ancho_cuenta(WIDTH);

    estado_t          estado;
    logic [PW-1:0]    mcando;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    suma;
    logic [WIDTH-1:0] mdor;
    logic [CW-1:0]    cuenta;
    logic             cout_unused;

    logic [PW-1:0]    acc_sig;
    logic [WIDTH-1:0] mdor_sig;
    logic             fin;

    sumadorCompletoN #(.WIDTH(PW)) u_sumador (
        .a    (acc),
        .b    (mcando),
        .cin  (1'b0),
        .suma (suma),
        .cout (cout_unused)
    );

    always_comb begin
        acc_sig  = mdor[0] ? suma : acc;
        mdor_sig = mdor >> 1;
`ifdef MULT_EARLY_EXIT_EN
        fin = (cuenta == CW'(WIDTH - 1)) || (mdor_sig == '0);
`else
        fin = (cuenta == CW'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= IDLE;
            mcando    <= '0;
            acc       <= '0;
            mdor      <= '0;
            cuenta    <= '0;
            listo     <= 1'b1;
            valido    <= 1'b0;
            resultado <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    valido <= 1'b0;
                    if (inicio) begin
                        mcando <= {{WIDTH{1'b0}}, multiplicando};
                        mdor   <= multiplicador;
                        acc    <= '0;
                        cuenta <= '0;
                        listo  <= 1'b0;
                        estado <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_sig;
                    mcando <= mcando << 1;
                    mdor   <= mdor_sig;
                    cuenta <= cuenta + 1'b1;
                    // Product is published on the same edge that enters DONE.
                    if (fin) begin
                        resultado <= acc_sig;
                        valido    <= 1'b1;
                        estado    <= DONE;
                    end
                end
                DONE: begin
                    valido <= 1'b0;
                    listo  <= 1'b1;
                    estado <= IDLE;
                end
                default: begin
                    valido <= 1'b0;
                    listo  <= 1'b1;
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/controlador_multiplicador.md
# controlador_multiplicador

Sequential shift-and-add multiplier controller. It accepts two unsigned WIDTH-bit operands on a start pulse and sequences one shared 2*WIDTH-bit `sumadorCompletoN` over one multiplier bit per clock. It returns the exact 2*WIDTH-bit product with a one-cycle done pulse. It replaces the fully unrolled combinational multiplier where area matters more than latency.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- inicio  input  1  start request; honoured only while listo=1.
- multiplicando  input  WIDTH  unsigned operand A; sampled on accepted inicio.
- multiplicador  input  WIDTH  unsigned operand B; sampled on accepted inicio.
- listo  output  1  high only in IDLE; block can accept inicio.
- valido  output  1  one-cycle pulse; resultado holds a new product.
- resultado  output  2*WIDTH  registered product; held until the next accepted inicio.

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - listo=1.
  - On inicio=1: load the multiplicand register with zero-extended multiplicando (2*WIDTH bits), load the multiplier register with multiplicador, clear the accumulator and count, and go to CALC.
- CALC, one step per cycle:
  - If multiplier[0]=1, the accumulator takes the adder sum (A=accumulator, B=multiplicand, Cin=0). Otherwise the accumulator holds.
  - Multiplicand shifts left 1; multiplier shifts right 1; count increments.
  - Go to DONE when count==WIDTH-1, or on the early-exit condition (see Configuration). Otherwise stay in CALC.
- DONE:
  - The accumulator is copied into resultado on entry, and valido=1 for exactly this cycle.
  - Unconditionally return to IDLE.
- inicio during CALC or DONE is ignored, with no queuing. Operand inputs are don't-care after capture.
- Adder Cout is ignored. The product always fits in 2*WIDTH bits, so overflow is impossible.
- resultado is updated only on DONE entry. Its previous value stays stable throughout CALC.

## Timing
- Reset values: state=IDLE, listo=1, valido=0, resultado=0; all internal registers 0.
- inicio sampled high in cycle t (IDLE) → CALC occupies cycles t+1…t+WIDTH → valido=1 and the new resultado appear in cycle t+WIDTH+1 → listo=1 in cycle t+WIDTH+2.
- Throughput is one product per WIDTH+2 cycles. inicio held high continuously restarts in the first IDLE cycle.
- rst asserted in any state (including mid-CALC) immediately forces IDLE and clears resultado. No valido is produced for the aborted operation.
- The count register is $clog2(WIDTH)+1 bits, so it never wraps within an operation.

## Configuration
- MULT_EARLY_EXIT_EN:
  - Defined: CALC also exits to DONE when the post-shift multiplier register is zero. CALC lasts 1 cycle minimum, or (index of the highest set bit of multiplicador)+1 cycles. valido arrives at t+1+that count; multiplicador=0 or 1 gives valido at t+2.
  - Undefined: CALC always lasts exactly WIDTH cycles, giving fixed latency.
- The product value is identical either way.

## Structure
- Shared package multiplicador_pkg:
  - estado_t enum {IDLE, CALC, DONE}, 2-bit encoding.
  - Function for the count width ($clog2(WIDTH)+1).
- One sub-module: the existing sumadorCompletoN, instantiated once with WIDTH=2*WIDTH and Cin tied to 0.
- All sequencing, shifting and registers stay in controlador_multiplicador.

## Test plan
All scenarios use WIDTH=4.
- Reset with no stimulus → listo=1, valido=0, resultado=8'h00; rst pulsed mid-idle keeps these values.
- inicio with 15×15 at cycle t, macro off → valido high only in cycle t+5, resultado=8'hE1 (225), listo=0 during t+1…t+5.
- 13×11, with operands changed to 2×2 and inicio held high during CALC → resultado=8'h8F (143). A second operation starts at t+6 with 2×2 → resultado=8'h04.
- 0×9 and 9×0 → resultado=8'h00 both times. Macro off: valido at t+5. Macro on: 9×0 gives valido at t+2; 0×9 gives valido at t+5.
- rst asserted in the 2nd CALC cycle of 7×6 → no valido, resultado=0, listo=1. Then 3×5 → resultado=8'h0F at t+5.
- Macro on, 7×1 → valido at t+2, resultado=8'h07. Then 7×4 → valido at t+4, resultado=8'h1C.
